// File: rtl/xc_malu_long_seq.sv
// Self-sequencing multi-precision unit for xc.madd.3 / xc.msub.3 / xc.macc / xc.mmul.3.
// Accepts one request over valid/ready and returns a two-limb result over valid/ready.
module xc_malu_long_seq #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 1
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] rs3,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_lo,
   output logic [XLEN-1:0] rsp_hi,
   output logic            busy
);

   localparam int STEPS = XLEN / MUL_BITS;
   localparam int CNT_W = $clog2(STEPS);

   localparam logic [1:0] OP_MADD = 2'b00;
   localparam logic [1:0] OP_MSUB = 2'b01;
   localparam logic [1:0] OP_MACC = 2'b10;
   localparam logic [1:0] OP_MMUL = 2'b11;

   typedef enum logic [2:0] {IDLE, MUL, CALC, CARRY, DONE} state_t;

   state_t            state, state_nxt;
   logic [1:0]        op;
   logic [XLEN-1:0]   op_a, op_b, op_c;
   logic [XLEN-1:0]   acc_lo, acc_hi;
   logic              carry;
   logic [CNT_W-1:0]  count;
   logic              accept;

   logic [XLEN-1:0]          add_x, add_y;
   logic                     add_cin;
   logic [XLEN:0]            add_sum;
   logic [MUL_BITS-1:0]      mul_top;
   logic [XLEN+MUL_BITS-1:0] mul_pp;
   logic [2*XLEN-1:0]        acc_step;

   assign accept    = req_valid && (state == IDLE) && !flush;
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == DONE);
   assign rsp_lo    = acc_lo;
   assign rsp_hi    = acc_hi;

   // One XLEN-bit adder serves every CALC and CARRY step; msub is a + ~b + ~c0.
   always_comb begin
      add_x   = '0;
      add_y   = '0;
      add_cin = 1'b0;
      case (state)
         CALC: begin
            case (op)
               OP_MADD: begin add_x = op_a;   add_y = op_b;  add_cin = op_c[0];  end
               OP_MSUB: begin add_x = op_a;   add_y = ~op_b; add_cin = ~op_c[0]; end
               OP_MACC: begin add_x = op_b;   add_y = op_c;  end
               default: begin add_x = acc_lo; add_y = op_c;  end
            endcase
         end
         CARRY: begin add_x = acc_hi; add_cin = carry; end
         default: ;
      endcase
   end

   assign add_sum  = {1'b0, add_x} + {1'b0, add_y} + {{XLEN{1'b0}}, add_cin};
   assign mul_top  = op_b[XLEN-1 -: MUL_BITS];
   assign mul_pp   = {{MUL_BITS{1'b0}}, op_a} * {{XLEN{1'b0}}, mul_top};
   assign acc_step = ({acc_hi, acc_lo} << MUL_BITS) + {{(XLEN-MUL_BITS){1'b0}}, mul_pp};

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (req_op == OP_MMUL) ? MUL : CALC;
         MUL:     if (count == '0) state_nxt = CALC;
         CALC:    state_nxt = (op == OP_MADD || op == OP_MSUB) ? DONE : CARRY;
         CARRY:   state_nxt = DONE;
         DONE:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // Datapath freezes on flush so the result registers keep their last contents.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         op     <= 2'b00;
         op_a   <= '0;
         op_b   <= '0;
         op_c   <= '0;
         acc_lo <= '0;
         acc_hi <= '0;
         carry  <= 1'b0;
         count  <= '0;
      end else if (!flush) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op    <= req_op;
                  op_a  <= rs1;
                  op_b  <= rs2;
                  op_c  <= rs3;
                  carry <= 1'b0;
                  if (req_op == OP_MMUL) begin
                     acc_lo <= '0;
                     acc_hi <= '0;
                     count  <= CNT_W'(STEPS - 1);
                  end
               end
            end
            MUL: begin
               {acc_hi, acc_lo} <= acc_step;
               op_b             <= op_b << MUL_BITS;
               count            <= count - CNT_W'(1);
            end
            CALC: begin
               acc_lo <= add_sum[XLEN-1:0];
               carry  <= add_sum[XLEN];
               case (op)
                  OP_MADD: acc_hi <= {{(XLEN-1){1'b0}}, add_sum[XLEN]};
                  OP_MSUB: acc_hi <= {{(XLEN-1){1'b0}}, ~add_sum[XLEN]};
                  OP_MACC: acc_hi <= op_a;
                  default: ;
               endcase
            end
            CARRY:   acc_hi <= add_sum[XLEN-1:0];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_xc_malu_long_seq.sv
// Bench for xc_malu_long_seq: radix-1 and radix-4 instances share stimulus and
// are checked against a scoreboard of bench-computed results and latencies.
module tb_xc_malu_long_seq;

   logic        g_clk = 1'b0;
   logic        g_resetn = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] rs1 = '0, rs2 = '0, rs3 = '0;
   logic        rsp_ready1 = 1'b0, rsp_ready4 = 1'b0;
   logic        req_ready1, req_ready4, rsp_valid1, rsp_valid4, busy1, busy4;
   logic [31:0] rsp_lo1, rsp_hi1, rsp_lo4, rsp_hi4;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      int          lat;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, c, lo, hi;
   } vec_t;

   exp_t sb1[$];
   exp_t sb4[$];

   xc_malu_long_seq #(.XLEN(32), .MUL_BITS(1)) u_dut1 (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready1), .req_op(req_op),
      .rs1(rs1), .rs2(rs2), .rs3(rs3),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_lo(rsp_lo1), .rsp_hi(rsp_hi1), .busy(busy1)
   );

   xc_malu_long_seq #(.XLEN(32), .MUL_BITS(4)) u_dut4 (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready4), .req_op(req_op),
      .rs1(rs1), .rs2(rs2), .rs3(rs3),
      .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
      .rsp_lo(rsp_lo4), .rsp_hi(rsp_hi4), .busy(busy4)
   );

   always #5 g_clk = ~g_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
      logic [63:0] s;
      logic [32:0] rhs;
      s = '0;
      case (op)
         2'd0: s = {32'b0, a} + {32'b0, b} + {63'b0, c[0]};
         2'd1: begin
            rhs       = {1'b0, b} + {32'b0, c[0]};
            s[31:0]   = a - b - {31'b0, c[0]};
            s[63:32]  = 32'({1'b0, a} < rhs);
         end
         2'd2: begin
            s        = {32'b0, b} + {32'b0, c};
            s[63:32] = a + s[63:32];
         end
         default: s = {32'b0, a} * {32'b0, b} + {32'b0, c};
      endcase
      return s;
   endfunction

   function automatic int lat_of(input logic [1:0] op, input int mb);
      return (op == 2'd3) ? (32 / mb + 3) : ((op == 2'd2) ? 3 : 2);
   endfunction

   function automatic logic get_v(input int d);
      return (d == 0) ? rsp_valid1 : rsp_valid4;
   endfunction

   task automatic wait_rsp(input int d);
      int   n;
      exp_t e;
      n = 1;
      while (!get_v(d) && n < 100) begin
         @(posedge g_clk); #1;
         n++;
      end
      if ((d == 0 && sb1.size() == 0) || (d == 1 && sb4.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL sb_empty dut%0d: got response, expected none queued", d);
         return;
      end
      e = (d == 0) ? sb1.pop_front() : sb4.pop_front();
      chk($sformatf("latency dut%0d", d), 64'(n), 64'(e.lat));
      chk($sformatf("rsp_lo dut%0d", d), (d == 0) ? rsp_lo1 : rsp_lo4, e.lo);
      chk($sformatf("rsp_hi dut%0d", d), (d == 0) ? rsp_hi1 : rsp_hi4, e.hi);
      if (d == 0) rsp_ready1 = 1'b1; else rsp_ready4 = 1'b1;
      @(posedge g_clk); #1;
      if (d == 0) rsp_ready1 = 1'b0; else rsp_ready4 = 1'b0;
      chk($sformatf("rsp_valid_drop dut%0d", d), get_v(d), 1'b0);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] lo, input logic [31:0] hi);
      exp_t e;
      e.lo = lo; e.hi = hi;
      e.lat = lat_of(op, 1); sb1.push_back(e);
      e.lat = lat_of(op, 4); sb4.push_back(e);
      req_op = op; rs1 = a; rs2 = b; rs3 = c; req_valid = 1'b1;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      rs1 = $urandom; rs2 = $urandom; rs3 = $urandom;
      fork
         wait_rsp(0);
         wait_rsp(1);
      join
   endtask

   task automatic watch_silent(input string name);
      logic seen1, seen4;
      seen1 = 1'b0; seen4 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge g_clk); #1;
         seen1 |= rsp_valid1;
         seen4 |= rsp_valid4;
      end
      chk({name, " dut1"}, seen1, 1'b0);
      chk({name, " dut4"}, seen4, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        tbl[9];
      logic [63:0] m;
      logic [1:0]  rop;
      logic [31:0] ra, rb, rc;

      tbl[0] = '{2'd0, 32'hFFFF_FFFF, 32'd1,          32'd1,          32'h0000_0001, 32'd1};
      tbl[1] = '{2'd1, 32'd0,          32'd0,          32'd3,          32'hFFFF_FFFF, 32'd1};
      tbl[2] = '{2'd1, 32'd7,          32'd2,          32'd0,          32'd5,         32'd0};
      tbl[3] = '{2'd1, 32'd5,          32'd5,          32'd1,          32'hFFFF_FFFF, 32'd1};
      tbl[4] = '{2'd1, 32'd5,          32'd4,          32'd1,          32'd0,         32'd0};
      tbl[5] = '{2'd2, 32'd5,          32'hFFFF_FFFF, 32'd2,          32'd1,         32'd6};
      tbl[6] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,          32'd1,         32'd0};
      tbl[7] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF};
      tbl[8] = '{2'd3, 32'd3,          32'd5,          32'd7,          32'd22,        32'd0};

      #1 g_resetn = 1'b0;
      repeat (3) @(posedge g_clk);
      #1;
      chk("reset req_ready", req_ready1, 1'b1);
      chk("reset busy", busy1, 1'b0);
      chk("reset rsp_valid", rsp_valid1, 1'b0);
      chk("reset rsp_lo", rsp_lo1, 32'd0);
      chk("reset rsp_hi", rsp_hi4, 32'd0);
      g_resetn = 1'b1;
      @(posedge g_clk); #1;
      chk("post-reset req_ready4", req_ready4, 1'b1);

      for (int i = 0; i < 9; i++)
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].lo, tbl[i].hi);

      for (int i = 0; i < 10; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom; rb = $urandom; rc = $urandom;
         m = model(rop, ra, rb, rc);
         run_op(rop, ra, rb, rc, m[31:0], m[63:32]);
      end

      // Backpressure: macc held in DONE, a competing request must be ignored.
      req_op = 2'd2; rs1 = 32'd5; rs2 = 32'hFFFF_FFFF; rs3 = 32'd2; req_valid = 1'b1;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      repeat (2) begin @(posedge g_clk); #1; end
      chk("bp valid", rsp_valid1, 1'b1);
      chk("bp valid4", rsp_valid4, 1'b1);
      chk("bp lo", rsp_lo1, 32'd1);
      chk("bp hi", rsp_hi1, 32'd6);
      req_op = 2'd0; rs1 = 32'd1; rs2 = 32'd1; rs3 = 32'd0; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge g_clk); #1;
         chk($sformatf("hold%0d valid", i), rsp_valid1, 1'b1);
         chk($sformatf("hold%0d lo", i), rsp_lo1, 32'd1);
         chk($sformatf("hold%0d hi", i), rsp_hi1, 32'd6);
         chk($sformatf("hold%0d req_ready", i), req_ready1, 1'b0);
      end
      rsp_ready1 = 1'b1; rsp_ready4 = 1'b1;
      @(posedge g_clk); #1;
      rsp_ready1 = 1'b0; rsp_ready4 = 1'b0;
      chk("release valid", rsp_valid1, 1'b0);
      chk("release req_ready", req_ready1, 1'b1);
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      chk("b2b busy", busy1, 1'b1);
      chk("b2b busy4", busy4, 1'b1);
      @(posedge g_clk); #1;
      chk("b2b valid", rsp_valid1, 1'b1);
      chk("b2b lo", rsp_lo1, 32'd2);
      chk("b2b hi", rsp_hi1, 32'd0);
      rsp_ready1 = 1'b1; rsp_ready4 = 1'b1;
      @(posedge g_clk); #1;
      rsp_ready1 = 1'b0; rsp_ready4 = 1'b0;

      // flush beats a request presented in IDLE
      req_op = 2'd0; req_valid = 1'b1; flush = 1'b1;
      @(posedge g_clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      chk("flush-idle busy", busy1, 1'b0);

      // flush during MUL cycle 10
      req_op = 2'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; rs3 = 32'hFFFF_FFFF; req_valid = 1'b1;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      repeat (9) begin @(posedge g_clk); #1; end
      chk("pre-flush busy", busy1, 1'b1);
      flush = 1'b1;
      @(posedge g_clk); #1;
      flush = 1'b0;
      chk("flush busy", busy1, 1'b0);
      chk("flush busy4", busy4, 1'b0);
      chk("flush req_ready", req_ready1, 1'b1);
      watch_silent("flush no rsp");

      // asynchronous reset pulse mid-MUL
      req_valid = 1'b1;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      repeat (4) begin @(posedge g_clk); #1; end
      #2 g_resetn = 1'b0;
      #1;
      chk("rst-mid busy", busy1, 1'b0);
      chk("rst-mid lo", rsp_lo1, 32'd0);
      chk("rst-mid hi", rsp_hi1, 32'd0);
      #2 g_resetn = 1'b1;
      @(posedge g_clk); #1;
      watch_silent("reset no rsp");

      run_op(2'd0, 32'd2, 32'd3, 32'd1, 32'd6, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
